barrett_reduce_pipe: RTL

Parametrised, pipelined Barrett modular reducer. Computes dout_r = din_a mod Q for any 2K-bit input. Modulus Q and width K are set by parameters, and MU is derived at elaboration. Sits between multiplier outputs and downstream Galois-field datapaths, with a valid/ready stream interface, backpressure and a passthrough tag.

---
 rtl/barrett_reduce_pipe.sv | 90 +++++++++
 1 files changed

// File: rtl/barrett_reduce_pipe.sv
// Three-stage pipelined Barrett reducer: dout_r = din_a mod Q for a 2K-bit operand.
// The sideband tag follows its operand, and one global advance signal stalls every stage together.
module barrett_reduce_pipe #(
  parameter int Q     = 2027,
  parameter int K     = 11,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*K-1:0]   din_a,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     dout_r,
  output logic [TAG_W-1:0] out_tag
);

  localparam int AW = 2 * K;
  localparam int RW = K + 2;
  localparam logic [AW:0] TWO_2K = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] MU     = TWO_2K / (AW+1)'(Q);

  if (!((Q > (1 << (K - 1))) && (Q < (1 << K)))) begin : g_bad_modulus
    $error("barrett_reduce_pipe: Q must satisfy 2^(K-1) < Q < 2^K");
  end

  // Each call removes at most one multiple of Q.
  // Three cascaded calls clear the r < 4Q slack left by the quotient estimate.
  function automatic logic [RW-1:0] cond_sub(input logic [RW-1:0] r);
    return (r >= RW'(Q)) ? (r - RW'(Q)) : r;
  endfunction

  logic             adv;
  logic             vld_p0, vld_p1, vld_p2;
  logic [AW-1:0]    a_p0;
  logic [TAG_W-1:0] tag_p0, tag_p1;
  logic [AW:0]      prod_p0;
  logic [RW-1:0]    rem_p1;

  logic [K:0]       quot;
  logic [AW:0]      tq;
  logic [RW-1:0]    rem_next;

  assign adv       = !vld_p2 || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2;

  // The true remainder fits in RW bits, so a truncated subtraction gives the exact result.
  assign quot     = (K+1)'(prod_p0 >> K);
  assign tq       = (AW+1)'(quot) * (AW+1)'(Q);
  assign rem_next = RW'(a_p0) - RW'(tq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      a_p0    <= '0;
      tag_p0  <= '0;
      prod_p0 <= '0;
      tag_p1  <= '0;
      rem_p1  <= '0;
      dout_r  <= '0;
      out_tag <= '0;
    end else if (adv) begin
      // p0: capture the operand and the high-half times MU product
      vld_p0 <= in_valid;
      if (in_valid) begin
        a_p0    <= din_a;
        tag_p0  <= in_tag;
        prod_p0 <= (AW+1)'(din_a >> K) * MU;
      end
      // p1: coarse remainder a - t*Q, which lies in [0, 4Q)
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        tag_p1 <= tag_p0;
        rem_p1 <= rem_next;
      end
      // p2: final correction into [0, Q-1]
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        dout_r  <= K'(cond_sub(cond_sub(cond_sub(rem_p1))));
        out_tag <= tag_p1;
      end
    end
  end

endmodule
